instr_register_exec: RTL and testbench
======================================

INSTR_REGISTER_EXEC -- requirements
Module: instr_register_exec

Interface
REQ-001 Parameter OP_WIDTH, 32, operand width in bits (signed); legal 8..32.
REQ-002 Parameter DEPTH, 32, number of instruction entries; power of two, 4..64; AW = log2(DEPTH).
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 reset_n  input  1  reset is asynchronous and active-low.
REQ-005 load_en  input  1  write strobe, sampled on rising clk.
REQ-006 opcode  input  opcode_t  operation to store and execute.
REQ-007 operand_a, operand_b  input  OP_WIDTH each  signed operands.
REQ-008 write_pointer  input  AW  entry written when load_en=1.
REQ-009 read_pointer  input  AW  entry presented on instruction_word.
REQ-010 instruction_word  output  instruction_t  {opcode, operand_a, operand_b, result, div0} of read entry.
REQ-011 rd_valid  output  1  entry at read_pointer has been written since reset.
REQ-012 valid_count  output  AW+1  number of entries written at least once since reset.

Function
REQ-013 opcode_t SHALL encode ZERO=0, PASSA=1, PASSB=2, ADD=3, SUB=4, MULT=5, DIV=6, MOD=7.
REQ-014 result SHALL be signed, 2*OP_WIDTH bits; operands sign-extended before arithmetic.
REQ-015 ZERO->0; PASSA->a; PASSB->b; ADD->a+b; SUB->a-b; MULT->full signed a*b, no truncation.
REQ-016 DIV/MOD SHALL truncate toward zero (remainder takes sign of a); b=0 -> result 0 and div0=1, otherwise div0=0.
REQ-017 On rising clk with load_en=1, entry[write_pointer] SHALL capture opcode, operands, computed result and div0 in the same edge.
REQ-018 Result SHALL be computed from the values sampled at that edge; no multi-cycle ALU, no stall.
REQ-019 instruction_word and rd_valid SHALL be registered: they reflect entry[read_pointer] as sampled one clk edge earlier (1-cycle read latency).
REQ-020 Read and write to the same address in the same cycle SHALL return the old contents (read-before-write); new contents visible the following cycle.
REQ-021 Reading an entry never written since reset SHALL give instruction_word all-zero and rd_valid=0.
REQ-022 valid_count SHALL increment only on the first write to each entry; rewrites leave it unchanged; saturates at DEPTH.
REQ-023 Pointers are full-range AW bits; no out-of-range addresses exist, so no wrap logic beyond natural index.
REQ-024 load_en=0 SHALL leave all storage unchanged regardless of other inputs.

Reset
REQ-025 reset_n low SHALL immediately (without clk) clear all entries, all valid bits, instruction_word, rd_valid and valid_count to 0.
REQ-026 A write coinciding with reset assertion SHALL be discarded; first write is honoured on the first rising clk with reset_n high.
REQ-027 Reset mid-sequence SHALL behave identically to power-up reset.

Structure
REQ-028 opcode_t, operand_t, result_t, address_t, instruction_t and the opcode constants SHALL live in instr_register_pkg, extended with the OP_WIDTH-dependent types.
REQ-029 Arithmetic SHALL be a purely combinational sub-module instr_exec_alu (opcode, a, b -> result, div0), instantiated once on the write path.
REQ-030 Storage SHALL be a register array with a per-entry valid bit vector.

Verification
REQ-031 Reset then read every address -> instruction_word=0, rd_valid=0, valid_count=0.
REQ-032 Write ptr 3: MULT a=-7 b=6 -> next-cycle read ptr 3 gives result=-42, div0=0, rd_valid=1, valid_count=1.
REQ-033 DIV a=-7 b=2 -> result=-3; MOD same -> result=-1; DIV a=5 b=0 -> result=0, div0=1.
REQ-034 OP_WIDTH=32: MULT a=32'h7FFFFFFF b=32'h7FFFFFFF -> result=64'h3FFFFFFF00000001; SUB a=-2^31 b=1 -> -2147483649 without overflow.
REQ-035 Same-cycle write and read ptr 5 (old ADD 1+1, new PASSA 9) -> read shows 2, following cycle shows 9; rewrites keep valid_count unchanged.
REQ-036 Fill all DEPTH entries, assert reset_n low between clk edges -> outputs zero immediately, valid_count=0, write coincident with reset not stored.

Source files
------------

// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register / execute block.
// Holds the opcode encoding and the default-width operand, result, address
// and instruction types. The top and the ALU take OP_WIDTH and DEPTH as
// parameters. They build their own width-matched struct with the same field
// order as instruction_t.
package instr_register_pkg;

  typedef enum logic [2:0] {
    ZERO  = 3'd0,
    PASSA = 3'd1,
    PASSB = 3'd2,
    ADD   = 3'd3,
    SUB   = 3'd4,
    MULT  = 3'd5,
    DIV   = 3'd6,
    MOD   = 3'd7
  } opcode_t;

  localparam int OP_WIDTH_DEF = 32;
  localparam int DEPTH_DEF    = 32;
  localparam int AW_DEF       = $clog2(DEPTH_DEF);

  typedef logic signed [OP_WIDTH_DEF-1:0]   operand_t;
  typedef logic signed [2*OP_WIDTH_DEF-1:0] result_t;
  typedef logic        [AW_DEF-1:0]         address_t;

  // Field order, MSB first: opcode, operand_a, operand_b, result, div0.
  typedef struct packed {
    opcode_t  opcode;
    operand_t operand_a;
    operand_t operand_b;
    result_t  result;
    logic     div0;
  } instruction_t;

  // Packed width of an instruction entry for a given operand width.
  function automatic int instr_width(input int op_width);
    return 3 + 4 * op_width + 1;
  endfunction

endpackage

// File: rtl/instr_exec_alu.sv
// Combinational execute unit.
// Ports:
//   opcode  - operation to perform
//   a, b    - signed operands, OP_WIDTH bits
//   result  - signed result, 2*OP_WIDTH bits (full-precision product)
//   div0    - set when DIV/MOD sees b == 0 (result forced to 0)
module instr_exec_alu
  import instr_register_pkg::*;
#(
  parameter int OP_WIDTH = 32
) (
  input  opcode_t                       opcode,
  input  logic signed [OP_WIDTH-1:0]    a,
  input  logic signed [OP_WIDTH-1:0]    b,
  output logic signed [2*OP_WIDTH-1:0]  result,
  output logic                          div0
);

  localparam int RW = 2 * OP_WIDTH;

  logic signed [RW-1:0] a_ext;
  logic signed [RW-1:0] b_ext;

  // Extend before arithmetic so ADD/SUB never overflow and MULT keeps all bits.
  assign a_ext = {{OP_WIDTH{a[OP_WIDTH-1]}}, a};
  assign b_ext = {{OP_WIDTH{b[OP_WIDTH-1]}}, b};

  // Signed / and % truncate toward zero, and the remainder follows the dividend.
  always_comb begin
    result = '0;
    div0   = 1'b0;
    case (opcode)
      ZERO:  result = '0;
      PASSA: result = a_ext;
      PASSB: result = b_ext;
      ADD:   result = a_ext + b_ext;
      SUB:   result = a_ext - b_ext;
      MULT:  result = a_ext * b_ext;
      DIV: begin
        if (b == '0) div0   = 1'b1;
        else         result = a_ext / b_ext;
      end
      MOD: begin
        if (b == '0) div0   = 1'b1;
        else         result = a_ext % b_ext;
      end
    endcase
  end

endmodule

// File: rtl/instr_register_exec.sv
// Instruction register file with execute-on-write.
// A write stores the opcode, the operands and the ALU result/div0 computed
// from the same sampled inputs. A read returns entry[read_pointer] one clock
// later. A read and a write to one address in the same cycle returns the old
// contents.
// Ports:
//   clk, reset_n     - clock; asynchronous active-low reset
//   load_en          - write strobe
//   opcode           - operation to execute and store
//   operand_a/b      - signed operands
//   write_pointer    - entry written when load_en=1
//   read_pointer     - entry presented on instruction_word next cycle
//   instruction_word - {opcode, operand_a, operand_b, result, div0}
//   rd_valid         - read entry has been written since reset
//   valid_count      - number of distinct entries written since reset
module instr_register_exec
  import instr_register_pkg::*;
#(
  parameter  int OP_WIDTH = 32,
  parameter  int DEPTH    = 32,
  localparam int AW       = $clog2(DEPTH),
  localparam int IW       = instr_width(OP_WIDTH)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        load_en,
  input  opcode_t                     opcode,
  input  logic signed [OP_WIDTH-1:0]  operand_a,
  input  logic signed [OP_WIDTH-1:0]  operand_b,
  input  logic        [AW-1:0]        write_pointer,
  input  logic        [AW-1:0]        read_pointer,
  output logic        [IW-1:0]        instruction_word,
  output logic                        rd_valid,
  output logic        [AW:0]          valid_count
);

  typedef struct packed {
    opcode_t                      opcode;
    logic signed [OP_WIDTH-1:0]   operand_a;
    logic signed [OP_WIDTH-1:0]   operand_b;
    logic signed [2*OP_WIDTH-1:0] result;
    logic                         div0;
  } entry_t;

  // The count can only reach DEPTH because it increments once per entry.
  // Saturating anyway keeps it in range if that invariant is ever broken.
  function automatic logic [AW:0] sat_inc(input logic [AW:0] v);
    if (v >= (AW+1)'(DEPTH)) return v;
    return v + (AW+1)'(1);
  endfunction

  entry_t                       entries [DEPTH];
  logic [DEPTH-1:0]             entry_vld;
  logic [AW:0]                  count_q;

  logic signed [2*OP_WIDTH-1:0] alu_result_p0;
  logic                         alu_div0_p0;

  entry_t                       rd_entry_p1;
  logic                         vld_p1;

  // ---- stage p0: execute on the write path ----
  instr_exec_alu #(.OP_WIDTH(OP_WIDTH)) u_alu (
    .opcode (opcode),
    .a      (operand_a),
    .b      (operand_b),
    .result (alu_result_p0),
    .div0   (alu_div0_p0)
  );

  // ---- stage p1: storage update and registered read ----
  // Unwritten entries are held at zero, so a raw read already gives the
  // all-zero word. The read uses pre-edge contents, which gives the
  // read-before-write behaviour.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
      entry_vld   <= '0;
      count_q     <= '0;
      rd_entry_p1 <= '0;
      vld_p1      <= 1'b0;
    end else begin
      rd_entry_p1 <= entries[read_pointer];
      vld_p1      <= entry_vld[read_pointer];
      if (load_en) begin
        entries[write_pointer]   <= {opcode, operand_a, operand_b, alu_result_p0, alu_div0_p0};
        entry_vld[write_pointer] <= 1'b1;
        if (!entry_vld[write_pointer]) count_q <= sat_inc(count_q);
      end
    end
  end

  assign instruction_word = rd_entry_p1;
  assign rd_valid         = vld_p1;
  assign valid_count      = count_q;

endmodule

// File: tb/tb_instr_register_exec.sv
module tb_instr_register_exec;
  import instr_register_pkg::*;

  localparam int W  = 32;
  localparam int D  = 32;
  localparam int AW = 5;
  localparam int IW = 3 + 4 * W + 1;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 load_en;
  opcode_t              opcode;
  logic signed [W-1:0]  operand_a;
  logic signed [W-1:0]  operand_b;
  logic [AW-1:0]        write_pointer;
  logic [AW-1:0]        read_pointer;
  logic [IW-1:0]        instruction_word;
  logic                 rd_valid;
  logic [AW:0]          valid_count;

  always #5 clk = ~clk;

  instr_register_exec #(.OP_WIDTH(W), .DEPTH(D)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .load_en          (load_en),
    .opcode           (opcode),
    .operand_a        (operand_a),
    .operand_b        (operand_b),
    .write_pointer    (write_pointer),
    .read_pointer     (read_pointer),
    .instruction_word (instruction_word),
    .rd_valid         (rd_valid),
    .valid_count      (valid_count)
  );

  int checks   = 0;
  int failures = 0;

  // Reference contents: one packed word per entry plus written flags.
  logic [IW-1:0] m_word [D];
  bit            m_v    [D];
  int            m_cnt;

  task automatic check_val(input string tag, input logic [IW-1:0] got, input logic [IW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < D; i++) begin
      m_word[i] = '0;
      m_v[i]    = 1'b0;
    end
    m_cnt = 0;
  endtask

  // Division by magnitudes with sign applied afterwards: truncation toward
  // zero, and the remainder is whatever is left of a.
  function automatic void alu_ref(input logic [2:0] op, input logic signed [W-1:0] a,
                                  input logic signed [W-1:0] b,
                                  output logic signed [63:0] res, output logic d0);
    longint sa, sb, q, mag_a, mag_b;
    sa  = longint'(a);
    sb  = longint'(b);
    res = 0;
    d0  = 1'b0;
    case (op)
      3'd0: res = 0;
      3'd1: res = sa;
      3'd2: res = sb;
      3'd3: res = sa + sb;
      3'd4: res = sa - sb;
      3'd5: res = sa * sb;
      default: begin
        if (sb == 0) begin
          d0 = 1'b1;
        end else begin
          mag_a = (sa < 0) ? -sa : sa;
          mag_b = (sb < 0) ? -sb : sb;
          q     = mag_a / mag_b;
          if ((sa < 0) != (sb < 0)) q = -q;
          res = (op == 3'd6) ? q : sa - q * sb;
        end
      end
    endcase
  endfunction

  // One clock: drive inputs, predict the registered read from pre-edge
  // contents, apply the write to the model, then check after the edge.
  task automatic cycle(input string tag, input logic le, input logic [2:0] op,
                       input logic signed [W-1:0] a, input logic signed [W-1:0] b,
                       input int wp, input int rp);
    logic [IW-1:0]      exp_w;
    logic               exp_v;
    logic signed [63:0] r;
    logic               d;
    load_en       = le;
    opcode        = opcode_t'(op);
    operand_a     = a;
    operand_b     = b;
    write_pointer = wp[AW-1:0];
    read_pointer  = rp[AW-1:0];
    exp_w = m_word[rp];
    exp_v = m_v[rp];
    if (le) begin
      alu_ref(op, a, b, r, d);
      m_word[wp] = {op, a, b, r, d};
      if (!m_v[wp]) begin
        m_v[wp] = 1'b1;
        m_cnt++;
      end
    end
    @(posedge clk);
    #1;
    check_val({tag, ".word"},  instruction_word, exp_w);
    check_val({tag, ".valid"}, IW'(rd_valid),    IW'(exp_v));
    check_val({tag, ".count"}, IW'(valid_count), IW'(m_cnt));
  endtask

  function automatic logic [IW-1:0] res_field(input logic [IW-1:0] w);
    return IW'(w[64:1]);
  endfunction

  logic [IW-1:0] tmp_w;
  int            cnt_before;

  initial begin
    reset_n       = 1'b0;
    load_en       = 1'b1;
    opcode        = ADD;
    operand_a     = 32'sd3;
    operand_b     = 32'sd4;
    write_pointer = '0;
    read_pointer  = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_val("reset.word",  instruction_word, '0);
    check_val("reset.valid", IW'(rd_valid),    '0);
    check_val("reset.count", IW'(valid_count), '0);
    reset_n = 1'b1;

    // Every address unwritten after reset.
    for (int r = 0; r < D; r++) cycle("rst_read", 1'b0, 3'd3, 32'sd1, 32'sd1, r, r);

    // MULT -7 * 6 at entry 3.
    cycle("mult_wr", 1'b1, 3'd5, -32'sd7, 32'sd6, 3, 0);
    cycle("mult_rd", 1'b0, 3'd0, 0, 0, 0, 3);
    check_val("mult.res",   res_field(instruction_word), IW'(64'hFFFF_FFFF_FFFF_FFD6));
    check_val("mult.div0",  IW'(instruction_word[0]), '0);
    check_val("mult.valid", IW'(rd_valid), IW'(1'b1));
    check_val("mult.count", IW'(valid_count), IW'(1));

    // DIV / MOD sign handling and divide by zero.
    cycle("div_wr",  1'b1, 3'd6, -32'sd7, 32'sd2, 4, 0);
    cycle("mod_wr",  1'b1, 3'd7, -32'sd7, 32'sd2, 6, 0);
    cycle("div0_wr", 1'b1, 3'd6,  32'sd5, 32'sd0, 7, 0);
    cycle("div_rd",  1'b0, 3'd0, 0, 0, 0, 4);
    check_val("div.res",  res_field(instruction_word), IW'(64'hFFFF_FFFF_FFFF_FFFD));
    cycle("mod_rd",  1'b0, 3'd0, 0, 0, 0, 6);
    check_val("mod.res",  res_field(instruction_word), IW'(64'hFFFF_FFFF_FFFF_FFFF));
    cycle("div0_rd", 1'b0, 3'd0, 0, 0, 0, 7);
    check_val("div0.res", res_field(instruction_word), '0);
    check_val("div0.flag", IW'(instruction_word[0]), IW'(1'b1));

    // Full-width extremes.
    cycle("maxmul_wr", 1'b1, 3'd5, 32'sh7FFF_FFFF, 32'sh7FFF_FFFF, 8, 0);
    cycle("minsub_wr", 1'b1, 3'd4, 32'sh8000_0000, 32'sd1, 9, 0);
    cycle("maxmul_rd", 1'b0, 3'd0, 0, 0, 0, 8);
    check_val("maxmul.res", res_field(instruction_word), IW'(64'h3FFF_FFFF_0000_0001));
    cycle("minsub_rd", 1'b0, 3'd0, 0, 0, 0, 9);
    check_val("minsub.res", res_field(instruction_word), IW'(64'hFFFF_FFFF_7FFF_FFFF));

    // Same-cycle read and write of entry 5.
    cycle("rbw_old", 1'b1, 3'd3, 32'sd1, 32'sd1, 5, 0);
    cnt_before = m_cnt;
    cycle("rbw_new", 1'b1, 3'd1, 32'sd9, 32'sd0, 5, 5);
    check_val("rbw.old_res", res_field(instruction_word), IW'(64'd2));
    cycle("rbw_next", 1'b0, 3'd0, 0, 0, 0, 5);
    check_val("rbw.new_res", res_field(instruction_word), IW'(64'd9));
    check_val("rbw.count",   IW'(valid_count), IW'(cnt_before));

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      logic signed [W-1:0] ra, rb;
      ra = (($urandom % 4) == 0) ? W'($urandom_range(0, 20)) - 32'sd10 : W'($urandom);
      rb = (($urandom % 8) == 0) ? '0 :
           (($urandom % 3) == 0) ? W'($urandom_range(0, 20)) - 32'sd10 : W'($urandom);
      cycle("rand", (($urandom % 10) < 7), 3'($urandom), ra, rb,
            int'($urandom_range(0, D-1)), int'($urandom_range(0, D-1)));
    end

    // Fill every entry, then reset between edges while a write is pending.
    for (int i = 0; i < D; i++)
      cycle("fill", 1'b1, 3'($urandom), W'($urandom), W'($urandom_range(1, 100)), i, i);
    check_val("fill.count", IW'(valid_count), IW'(D));
    load_en       = 1'b1;
    opcode        = ADD;
    operand_a     = 32'sd11;
    operand_b     = 32'sd22;
    write_pointer = 5'd2;
    read_pointer  = 5'd2;
    reset_n       = 1'b0;
    #1;
    check_val("async_rst.word",  instruction_word, '0);
    check_val("async_rst.valid", IW'(rd_valid),    '0);
    check_val("async_rst.count", IW'(valid_count), '0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    load_en = 1'b0;
    reset_n = 1'b1;
    cycle("post_rst2", 1'b0, 3'd0, 0, 0, 0, 2);
    cycle("post_rst0", 1'b0, 3'd0, 0, 0, 0, 0);
    tmp_w = instruction_word;
    check_val("post_rst.zero", tmp_w, '0);
    cycle("first_wr", 1'b1, 3'd3, 32'sd11, 32'sd22, 2, 2);
    cycle("first_rd", 1'b0, 3'd0, 0, 0, 0, 2);
    check_val("first.res", res_field(instruction_word), IW'(64'd33));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
